// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with expiry pulse and sticky expired level.
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN (periodic reload at terminal count).
module countdown_timer #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [DATA_WIDTH-1:0]     load_count,
   input  logic [PRESCALE_WIDTH-1:0] load_prescale,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      ack,
   output logic [DATA_WIDTH-1:0]     count,
   output logic                      busy,
   output logic                      expired_pulse,
   output logic                      expired
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADED  = 2'd1,
      ST_RUNNING = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [DATA_WIDTH-1:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]     reload_q, reload_d;
   logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
   logic [PRESCALE_WIDTH-1:0] presc_reg_q, presc_reg_d;
   logic                      busy_q, busy_d;
   logic                      pulse_q, pulse_d;
   logic                      expired_q, expired_d;
   logic                      load_ready_q, load_ready_d;

   logic load_acc_c;
   logic tick_c;
   logic terminal_c;
   logic start_ok_c;

   assign load_acc_c = load_valid && load_ready_q;
   assign tick_c     = (presc_cnt_q == '0);
   assign terminal_c = (state_q == ST_RUNNING) && tick_c && (count_q == DATA_WIDTH'(1));
   // stop beats start, load beats start
   assign start_ok_c = start && !stop && !load_acc_c;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (load_acc_c) state_d = ST_LOADED;
         end
         ST_LOADED: begin
            if (load_acc_c)                      state_d = ST_LOADED;
            else if (start_ok_c && count_q == '0) state_d = ST_EXPIRED;
            else if (start_ok_c)                 state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            // terminal decrement takes precedence over stop
            if (terminal_c) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
               state_d = ST_RUNNING;
`else
               state_d = ST_EXPIRED;
`endif
            end else if (stop) begin
               state_d = ST_LOADED;
            end
         end
         ST_EXPIRED: begin
            if (load_acc_c || ack) state_d = ST_LOADED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d      = count_q;
      reload_d     = reload_q;
      presc_cnt_d  = presc_cnt_q;
      presc_reg_d  = presc_reg_q;
      pulse_d      = 1'b0;
      busy_d       = (state_d == ST_RUNNING);
      expired_d    = (state_d == ST_EXPIRED);
      load_ready_d = (state_d != ST_RUNNING);

      if (load_acc_c) begin
         reload_d    = load_count;
         presc_reg_d = load_prescale;
         count_d     = load_count;
         presc_cnt_d = load_prescale;
      end

      unique case (state_q)
         ST_LOADED: begin
            if (start_ok_c && count_q == '0) pulse_d = 1'b1;
         end
         ST_RUNNING: begin
            if (terminal_c) begin
               pulse_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
               count_d     = reload_q;
               presc_cnt_d = presc_reg_q;
`else
               count_d     = '0;
`endif
            end else if (stop) begin
               presc_cnt_d = presc_reg_q;
            end else if (tick_c) begin
               presc_cnt_d = presc_reg_q;
               if (count_q != '0) count_d = count_q - DATA_WIDTH'(1);
            end else begin
               presc_cnt_d = presc_cnt_q - PRESCALE_WIDTH'(1);
            end
         end
         ST_EXPIRED: begin
            if (!load_acc_c && ack) begin
               count_d     = reload_q;
               presc_cnt_d = presc_reg_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q      <= '0;
         reload_q     <= '0;
         presc_cnt_q  <= '0;
         presc_reg_q  <= '0;
         busy_q       <= 1'b0;
         pulse_q      <= 1'b0;
         expired_q    <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         count_q      <= count_d;
         reload_q     <= reload_d;
         presc_cnt_q  <= presc_cnt_d;
         presc_reg_q  <= presc_reg_d;
         busy_q       <= busy_d;
         pulse_q      <= pulse_d;
         expired_q    <= expired_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign count         = count_q;
   assign busy          = busy_q;
   assign expired_pulse = pulse_q;
   assign expired       = expired_q;
   assign load_ready    = load_ready_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a
// model that derives the count from elapsed running time.
module tb_countdown_timer;
   localparam int unsigned DW = 16;
   localparam int unsigned PW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_valid = 1'b0;
   logic [DW-1:0] load_count = '0;
   logic [PW-1:0] load_prescale = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          ack = 1'b0;
   logic          load_ready;
   logic [DW-1:0] count;
   logic          busy;
   logic          expired_pulse;
   logic          expired;

   countdown_timer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_count(load_count), .load_prescale(load_prescale),
      .start(start), .stop(stop), .ack(ack),
      .count(count), .busy(busy),
      .expired_pulse(expired_pulse), .expired(expired)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: while running, count = base - elapsed/(P+1); expiry at elapsed == base*(P+1)
   localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_EXP = 3;
   int m_state = M_IDLE;
   int m_count = 0, m_base = 0, m_elapsed = 0, m_reload = 0, m_presc = 0;
   bit m_pulse = 1'b0;

   function automatic void m_load();
      m_reload = int'(load_count);
      m_presc  = int'(load_prescale);
      m_count  = int'(load_count);
      m_state  = M_LOADED;
   endfunction

   always @(posedge clk) begin : model
      int  period;
      bit  load_acc;
      if (!rst) begin
         m_state = M_IDLE; m_count = 0; m_pulse = 1'b0;
         m_reload = 0; m_presc = 0; m_base = 0; m_elapsed = 0;
      end else begin
         m_pulse  = 1'b0;
         load_acc = load_valid && (m_state != M_RUN);
         period   = m_presc + 1;
         case (m_state)
            M_IDLE:   if (load_acc) m_load();
            M_LOADED: begin
               if (load_acc) m_load();
               else if (start && !stop) begin
                  if (m_count == 0) begin
                     m_state = M_EXP; m_pulse = 1'b1;
                  end else begin
                     m_state = M_RUN; m_base = m_count; m_elapsed = 0;
                  end
               end
            end
            M_RUN: begin
               m_elapsed++;
               if (m_elapsed == m_base * period) begin
                  m_pulse = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                  m_count = m_reload; m_base = m_reload; m_elapsed = 0;
`else
                  m_count = 0; m_state = M_EXP;
`endif
               end else if (stop) begin
                  m_state = M_LOADED;
               end else begin
                  m_count = m_base - m_elapsed / period;
               end
            end
            default: begin
               if (load_acc) m_load();
               else if (ack) begin
                  m_count = m_reload; m_state = M_LOADED;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cmp_count", int'(count), m_count);
         chk("cmp_busy", int'(busy), int'(m_state == M_RUN));
         chk("cmp_expired", int'(expired), int'(m_state == M_EXP));
         chk("cmp_pulse", int'(expired_pulse), int'(m_pulse));
         chk("cmp_load_ready", int'(load_ready), int'(m_state != M_RUN));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int n, input int p);
      load_valid = 1'b1; load_count = DW'(n); load_prescale = PW'(p);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!expired_pulse && n < 2000);
   endtask

   int n;

   initial begin
      rst = 1'b0;
      tick();
      cmp_en = 1'b1;
      tick();
      rst = 1'b1;
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_expired", int'(expired), 0);
      chk("rst_load_ready", int'(load_ready), 1);
      pulse_start();
      chk("idle_start_busy", int'(busy), 0);

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      // N=5 P=0 one-shot
      do_load(5, 0);
      pulse_start();
      chk("n5_count_after_start", int'(count), 5);
      wait_pulse(n);
      chk("n5_latency", n, 5);
      chk("n5_count_zero", int'(count), 0);
      tick();
      chk("n5_pulse_one_cycle", int'(expired_pulse), 0);
      repeat (3) tick();
      chk("n5_expired_sticky", int'(expired), 1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("n5_ack_count", int'(count), 5);
      chk("n5_ack_expired", int'(expired), 0);
      chk("n5_ack_load_ready", int'(load_ready), 1);

      // N=3 P=2 with pause
      do_load(3, 2);
      pulse_start();
      repeat (3) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      chk("pause_count", int'(count), 2);
      chk("pause_busy", int'(busy), 0);
      repeat (10) tick();
      chk("pause_hold_count", int'(count), 2);
      pulse_start();
      wait_pulse(n);
      chk("resume_latency", n, 6);
      ack = 1'b1; tick(); ack = 1'b0;
`else
      do_load(4, 1);
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         wait_pulse(n);
         chk("auto_period", n, 8);
         chk("auto_count_reload", int'(count), 4);
         chk("auto_expired_low", int'(expired), 0);
         chk("auto_busy", int'(busy), 1);
      end
      stop = 1'b1; tick(); stop = 1'b0;
`endif

      // stop on the terminal decrement edge
      do_load(2, 0);
      pulse_start();
      tick();
      stop = 1'b1; tick(); stop = 1'b0;
      chk("term_stop_pulse", int'(expired_pulse), 1);
`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      chk("term_stop_expired", int'(expired), 1);
      ack = 1'b1; tick(); ack = 1'b0;
`else
      chk("term_stop_busy", int'(busy), 1);
      stop = 1'b1; tick(); stop = 1'b0;
`endif

      // load ignored while running
      do_load(20, 0);
      pulse_start();
      tick();
      chk("run_load_ready", int'(load_ready), 0);
      do_load(7, 0);
      chk("run_load_ignored", int'(count), 18);
      chk("run_load_busy", int'(busy), 1);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("stop_holds_count", int'(count), 18);

      // load beats start in LOADED
      load_valid = 1'b1; load_count = DW'(9); load_prescale = PW'(3); start = 1'b1;
      tick();
      load_valid = 1'b0; start = 1'b0;
      chk("load_start_count", int'(count), 9);
      chk("load_start_busy", int'(busy), 0);

      // stop beats start while running
      pulse_start();
      tick();
      stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
      chk("stop_start_busy", int'(busy), 0);

      // reset mid-run
      do_load(100, 0);
      pulse_start();
      repeat (60) tick();
      chk("midrun_count", int'(count), 40);
      rst = 1'b0; tick(); rst = 1'b1;
      chk("midrun_rst_count", int'(count), 0);
      chk("midrun_rst_busy", int'(busy), 0);
      chk("midrun_rst_pulse", int'(expired_pulse), 0);
      chk("midrun_rst_expired", int'(expired), 0);
      chk("midrun_rst_ready", int'(load_ready), 1);

      // N=0 start expires immediately; load beats ack
      do_load(0, 0);
      pulse_start();
      chk("n0_pulse", int'(expired_pulse), 1);
      chk("n0_expired", int'(expired), 1);
      tick();
      chk("n0_pulse_drop", int'(expired_pulse), 0);
      ack = 1'b1;
      do_load(6, 1);
      ack = 1'b0;
      chk("load_over_ack_count", int'(count), 6);
      chk("load_over_ack_expired", int'(expired), 0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         rst           = ($urandom_range(0, 299) != 0);
         load_valid    = ($urandom_range(0, 9) == 0);
         load_count    = DW'($urandom_range(0, 7));
         load_prescale = PW'($urandom_range(0, 3));
         start         = ($urandom_range(0, 4) == 0);
         stop          = ($urandom_range(0, 19) == 0);
         ack           = ($urandom_range(0, 9) == 0);
         tick();
      end
      rst = 1'b1; load_valid = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
      tick();
      @(posedge clk);
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
